state_estimator: RTL and testbench
==================================

STATE_ESTIMATOR -- requirements
Module: state_estimator

Interface
REQ-001 Parameters: WIDTH, default 16, word width of every signed fixed-point element.
REQ-002 Parameters: nos, default 4, number of states.
REQ-003 Parameters: noo, default 1, number of outputs.
REQ-004 Parameters: intDigits, default 8, integer bits; fractional bits FB = WIDTH - intDigits.
REQ-005 One clock; reset is synchronous and active-high. Ports: clk, input, 1, rising-edge clock.
REQ-006 reset, input, 1, synchronous active-high reset.
REQ-007 clk_en, input, 1, global enable; when 0 all registers hold.
REQ-008 Start_Prediction, input, 1, request for time update x_pred = A*x_hat.
REQ-009 Start_Update, input, 1, request for measurement update.
REQ-010 A, input, nos x nos x WIDTH, state matrix.
REQ-011 C, input, noo x nos x WIDTH, output matrix.
REQ-012 K, input, nos x noo x WIDTH, Kalman gain from covariance_matrix_generator t2; sampled only in CORR.
REQ-013 y, input, noo x WIDTH, measurement; sampled only in INNOV_SUB.
REQ-014 x0, input, nos x WIDTH, initial state loaded on reset.
REQ-015 x_hat, output, nos x WIDTH, current state estimate.
REQ-016 y_hat, output, noo x WIDTH, predicted output C*x_pred.
REQ-017 end_Prediction, output, 1, high while state == PRED_DONE.
REQ-018 end_Update, output, 1, high while state == UPD_DONE.

Function
REQ-019 States: IDLE, PRED, PRED_DONE, INNOV, INNOV_SUB, CORR, UPD_DONE; transitions occur only on clk_en=1 edges.
REQ-020 IDLE: Start_Prediction -> PRED; else Start_Update -> INNOV; both high -> PRED (prediction wins).
REQ-021 PRED: one multiply-accumulate per enabled cycle, row-major over A; nos*nos cycles; row i result written to x_pred[i] after its last term; then PRED_DONE.
REQ-022 PRED_DONE: on entry x_hat <= x_pred; holds until Start_Update -> INNOV; Start_Prediction ignored.
REQ-023 INNOV: computes y_hat = C*x_hat, noo*nos MAC cycles; then INNOV_SUB.
REQ-024 INNOV_SUB: one cycle; e[k] = y[k] - y_hat[k], wrap-around WIDTH subtraction; then CORR.
REQ-025 CORR: x_hat[i] += sum_k K[i][k]*e[k], nos*noo MAC cycles; x_hat row written after its last term; then UPD_DONE.
REQ-026 UPD_DONE: holds until Start_Prediction -> PRED; Start_Update ignored.
REQ-027 Arithmetic: products are 2*WIDTH signed; accumulator 2*WIDTH + clog2(nos) bits; result = accumulator bits [FB+WIDTH-1:FB] (truncate, wrap, no saturation); correction addend added to x_hat with WIDTH wrap.
REQ-028 Latency (nos=4, noo=1): end_Prediction rises 17 enabled cycles after the start edge; end_Update rises 18 enabled cycles after the Start_Update edge.
REQ-029 Starts are level-sampled only in IDLE, PRED_DONE, UPD_DONE; asserted in any other state they have no effect.
REQ-030 clk_en=0 mid-computation freezes counters, accumulator and state; result identical to uninterrupted run.

Reset
REQ-031 reset (with clk_en=1) in any state, including mid-computation: state <= IDLE, counters and accumulator <= 0, x_hat <= x0, x_pred <= x0, y_hat <= 0, e <= 0.
REQ-032 After reset, end_Prediction = 0 and end_Update = 0.

Structure
REQ-033 A shared package kf_pkg holds the state enum and the fixed-point truncation function used by all filter blocks.
REQ-034 One sub-module, fx_mac (single signed multiplier + accumulator with clear/enable), is instantiated once and time-shared.

Verification (nos=4, noo=1, WIDTH=16, intDigits=8)
REQ-035 A=I (diag 0x0100), x0=[1,2,3,4] (0x0100..0x0400), Start_Prediction pulse -> end_Prediction after 17 cycles, x_hat=[1,2,3,4].
REQ-036 Then C=[1,0,0,0], K=[0.5,0,0,0] (0x0080), y=3.0 (0x0300), Start_Update -> y_hat=0x0100, x_hat=[0x0200,0x0200,0x0300,0x0400], end_Update after 18 cycles.
REQ-037 A=2*I (0x0200), x0=[0x4000,...] -> x_hat[0]=0x8000 (wrap, no saturation).
REQ-038 Both starts high in IDLE -> PRED entered; Start_Prediction in PRED_DONE ignored.
REQ-039 reset asserted at cycle 5 of PRED -> next cycle IDLE, x_hat=x0, end flags 0.
REQ-040 clk_en toggled 0/1 every cycle during full predict+update -> identical x_hat, latency doubled in clk cycles.

Source files
------------

// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman filter blocks: estimator state encoding and
// the fixed-point truncation used to bring wide accumulators back to word width.
package kf_pkg;

  localparam int KF_MAXW = 64;

  typedef enum logic [2:0] {
    IDLE,
    PRED,
    PRED_DONE,
    INNOV,
    INNOV_SUB,
    CORR,
    UPD_DONE
  } kf_state_e;

  // Drops fb fractional bits; callers cast the result down to their word width.
  function automatic logic signed [KF_MAXW-1:0] fx_trunc(input logic signed [KF_MAXW-1:0] acc,
                                                          input int fb);
    return acc >>> fb;
  endfunction

endpackage

// File: rtl/fx_mac.sv
// Single signed multiplier feeding an accumulator; clr_i loads the product instead
// of adding it, so a new dot product starts without a dead cycle.
module fx_mac #(
  parameter int WIDTH = 16,
  parameter int ACC_W = 34
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic signed [ACC_W-1:0] acc_next_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;

  assign prod       = a_i * b_i;
  assign acc_next_o = clr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
  assign acc_o      = acc_q;

  always_ff @(posedge clk_i) begin
    if (ce_i) begin
      if (rst_i)     acc_q <= '0;
      else if (en_i) acc_q <= acc_next_o;
    end
  end

endmodule

// File: rtl/state_estimator.sv
// Kalman state estimator: time update x_pred = A*x_hat and measurement update
// x_hat += K*(y - C*x_hat), all dot products sequenced through one shared MAC.
module state_estimator
  import kf_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int nos       = 4,
  parameter int noo       = 1,
  parameter int intDigits = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clk_en,
  input  logic                                Start_Prediction,
  input  logic                                Start_Update,
  input  logic [nos-1:0][nos-1:0][WIDTH-1:0]  A,
  input  logic [noo-1:0][nos-1:0][WIDTH-1:0]  C,
  input  logic [nos-1:0][noo-1:0][WIDTH-1:0]  K,
  input  logic [noo-1:0][WIDTH-1:0]           y,
  input  logic [nos-1:0][WIDTH-1:0]           x0,
  output logic [nos-1:0][WIDTH-1:0]           x_hat,
  output logic [noo-1:0][WIDTH-1:0]           y_hat,
  output logic                                end_Prediction,
  output logic                                end_Update
);

  localparam int FB    = WIDTH - intDigits;
  localparam int ACC_W = 2*WIDTH + $clog2(nos);
  localparam int MAXD  = (nos > noo) ? nos : noo;
  localparam int CW    = $clog2(MAXD + 3);
  localparam logic [CW-1:0] NOS_C = CW'(nos);
  localparam logic [CW-1:0] NOO_C = CW'(noo);

  kf_state_e               state_q;
  logic [CW-1:0]           row_q, col_q;
  logic signed [WIDTH-1:0] x_hat_q  [nos];
  logic signed [WIDTH-1:0] x_pred_q [nos];
  logic signed [WIDTH-1:0] y_hat_q  [noo];
  logic signed [WIDTH-1:0] e_q      [noo];
  logic signed [WIDTH-1:0] add_q;

  logic                    mac_en, mac_clr;
  logic signed [WIDTH-1:0] mac_a, mac_b;
  logic signed [ACC_W-1:0] mac_acc_q, mac_acc_d;

  function automatic logic signed [WIDTH-1:0] fx_res(input logic signed [ACC_W-1:0] acc);
    return WIDTH'(fx_trunc(KF_MAXW'(acc), FB));
  endfunction

  fx_mac #(.WIDTH(WIDTH), .ACC_W(ACC_W)) u_mac (
    .clk_i      (clk),
    .rst_i      (reset),
    .ce_i       (clk_en),
    .en_i       (mac_en),
    .clr_i      (mac_clr),
    .a_i        (mac_a),
    .b_i        (mac_b),
    .acc_o      (mac_acc_q),
    .acc_next_o (mac_acc_d)
  );

  // Operand routing: row_q selects the output element, col_q the term.
  always_comb begin
    mac_en  = 1'b0;
    mac_clr = (col_q == '0);
    mac_a   = '0;
    mac_b   = '0;
    case (state_q)
      PRED: begin
        mac_en = (row_q != NOS_C);
        for (int i = 0; i < nos; i++)
          for (int j = 0; j < nos; j++)
            if (row_q == CW'(i) && col_q == CW'(j)) begin
              mac_a = A[i][j];
              mac_b = x_hat_q[j];
            end
      end
      INNOV: begin
        mac_en = (row_q != NOO_C);
        for (int i = 0; i < noo; i++)
          for (int j = 0; j < nos; j++)
            if (row_q == CW'(i) && col_q == CW'(j)) begin
              mac_a = C[i][j];
              mac_b = x_hat_q[j];
            end
      end
      CORR: begin
        mac_en = (col_q < NOO_C);
        for (int i = 0; i < nos; i++)
          for (int k = 0; k < noo; k++)
            if (row_q == CW'(i) && col_q == CW'(k)) begin
              mac_a = K[i][k];
              mac_b = e_q[k];
            end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk_en) begin
      if (reset) begin
        state_q <= IDLE;
        row_q   <= '0;
        col_q   <= '0;
        add_q   <= '0;
        for (int i = 0; i < nos; i++) begin
          x_hat_q[i]  <= x0[i];
          x_pred_q[i] <= x0[i];
        end
        for (int k = 0; k < noo; k++) begin
          y_hat_q[k] <= '0;
          e_q[k]     <= '0;
        end
      end else begin
        case (state_q)
          IDLE, UPD_DONE, PRED_DONE: begin
            row_q <= '0;
            col_q <= '0;
            if (Start_Prediction && state_q != PRED_DONE) state_q <= PRED;
            else if (Start_Update && state_q != UPD_DONE) state_q <= INNOV;
          end
          PRED: begin
            if (row_q == NOS_C) begin
              state_q <= PRED_DONE;
              x_hat_q <= x_pred_q;
            end else if (col_q == NOS_C - CW'(1)) begin
              for (int i = 0; i < nos; i++)
                if (row_q == CW'(i)) x_pred_q[i] <= fx_res(mac_acc_d);
              row_q <= row_q + CW'(1);
              col_q <= '0;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          INNOV: begin
            if (row_q == NOO_C) begin
              state_q <= INNOV_SUB;
            end else if (col_q == NOS_C - CW'(1)) begin
              for (int k = 0; k < noo; k++)
                if (row_q == CW'(k)) y_hat_q[k] <= fx_res(mac_acc_d);
              row_q <= row_q + CW'(1);
              col_q <= '0;
            end else begin
              col_q <= col_q + CW'(1);
            end
          end
          INNOV_SUB: begin
            for (int k = 0; k < noo; k++) e_q[k] <= $signed(y[k]) - y_hat_q[k];
            state_q <= CORR;
            row_q   <= '0;
            col_q   <= '0;
          end
          // Per row: noo MAC terms, one cycle to register the addend, one to apply it.
          CORR: begin
            if (col_q < NOO_C) begin
              col_q <= col_q + CW'(1);
            end else if (col_q == NOO_C) begin
              add_q <= fx_res(mac_acc_q);
              col_q <= col_q + CW'(1);
            end else begin
              for (int i = 0; i < nos; i++)
                if (row_q == CW'(i)) x_hat_q[i] <= x_hat_q[i] + add_q;
              col_q <= '0;
              if (row_q == NOS_C - CW'(1)) state_q <= UPD_DONE;
              else                         row_q   <= row_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < nos; i++) x_hat[i] = x_hat_q[i];
    for (int k = 0; k < noo; k++) y_hat[k] = y_hat_q[k];
  end

  assign end_Prediction = (state_q == PRED_DONE);
  assign end_Update     = (state_q == UPD_DONE);

endmodule

// File: tb/tb_state_estimator.sv
// Bench for state_estimator (nos=4, noo=1, Q8.8): vector table, corner sequences
// and random runs against an arithmetic reference of the filter equations.
module tb_state_estimator;

  localparam int W  = 16;
  localparam int NS = 4;
  localparam int NO = 1;

  typedef logic [NS-1:0][NS-1:0][W-1:0] mat_t;
  typedef logic [NO-1:0][NS-1:0][W-1:0] cmat_t;
  typedef logic [NS-1:0][NO-1:0][W-1:0] kmat_t;
  typedef logic [NS-1:0][W-1:0]         vec_t;

  typedef struct {
    mat_t        a;
    vec_t        x0;
    cmat_t       c;
    kmat_t       k;
    logic [15:0] y;
    vec_t        xp;
    logic [15:0] yh;
    vec_t        xu;
  } tv_t;

  logic clk = 1'b0;
  logic reset, clk_en, Start_Prediction, Start_Update;
  mat_t A;
  cmat_t C;
  kmat_t K;
  logic [NO-1:0][W-1:0] y;
  vec_t x0;
  vec_t x_hat;
  logic [NO-1:0][W-1:0] y_hat;
  logic end_Prediction, end_Update;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  state_estimator #(.WIDTH(W), .nos(NS), .noo(NO), .intDigits(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_en           (clk_en),
    .Start_Prediction (Start_Prediction),
    .Start_Update     (Start_Update),
    .A                (A),
    .C                (C),
    .K                (K),
    .y                (y),
    .x0               (x0),
    .x_hat            (x_hat),
    .y_hat            (y_hat),
    .end_Prediction   (end_Prediction),
    .end_Update       (end_Update)
  );

  // Reference arithmetic: exact sums, then keep bits [23:8] of the result.
  function automatic logic [15:0] tr(input longint s);
    longint t;
    t = s >>> 8;
    return t[15:0];
  endfunction

  function automatic vec_t m_pred(input mat_t a, input vec_t x);
    vec_t r;
    longint s;
    for (int i = 0; i < NS; i++) begin
      s = 0;
      for (int j = 0; j < NS; j++) s += longint'($signed(a[i][j])) * longint'($signed(x[j]));
      r[i] = tr(s);
    end
    return r;
  endfunction

  function automatic logic [15:0] m_yh(input cmat_t c, input vec_t x);
    longint s;
    s = 0;
    for (int j = 0; j < NS; j++) s += longint'($signed(c[0][j])) * longint'($signed(x[j]));
    return tr(s);
  endfunction

  function automatic vec_t m_upd(input kmat_t k, input vec_t x, input logic [15:0] yy,
                                 input logic [15:0] yh);
    vec_t r;
    logic [15:0] e;
    e = yy - yh;
    for (int i = 0; i < NS; i++)
      r[i] = x[i] + tr(longint'($signed(k[i][0])) * longint'($signed(e)));
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] v0, input logic [15:0] v1,
                              input logic [15:0] v2, input logic [15:0] v3);
    vec_t r;
    r[0] = v0; r[1] = v1; r[2] = v2; r[3] = v3;
    return r;
  endfunction

  function automatic mat_t fill(input logic [15:0] d, input logic [15:0] o);
    mat_t m;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++) m[i][j] = (i == j) ? d : o;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; clk_en = 1'b1; Start_Prediction = 1'b0; Start_Update = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic load(input tv_t t);
    @(negedge clk);
    A = t.a; x0 = t.x0; C = t.c; K = t.k; y[0] = t.y;
  endtask

  // Pulses a start for one edge and counts edges until the matching done flag.
  task automatic run_start(input bit pred, input bit both, input bit toggle, output int n);
    @(negedge clk);
    clk_en = 1'b1;
    Start_Prediction = pred | both;
    Start_Update     = !pred | both;
    @(posedge clk);
    #1 Start_Prediction = 1'b0; Start_Update = 1'b0;
    n = 0;
    while (n < 200) begin
      if (toggle) clk_en = ~clk_en;
      @(posedge clk);
      #1 n++;
      if (pred ? end_Prediction : end_Update) break;
    end
    clk_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    tv_t tv[3];
    tv_t r;
    vec_t xp, xu;
    logic [15:0] yh;
    int n;

    reset = 1'b0; clk_en = 1'b1; Start_Prediction = 1'b0; Start_Update = 1'b0;
    A = '0; C = '0; K = '0; y = '0; x0 = '0;

    tv[0].a = fill(16'h0100, 16'h0000);
    tv[0].x0 = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    tv[0].c[0] = mk(16'h0100, 16'h0000, 16'h0000, 16'h0000);
    tv[0].k = mk(16'h0080, 16'h0000, 16'h0000, 16'h0000);
    tv[0].y = 16'h0300;
    tv[0].xp = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    tv[0].yh = 16'h0100;
    tv[0].xu = mk(16'h0200, 16'h0200, 16'h0300, 16'h0400);

    tv[1].a = fill(16'h0200, 16'h0000);
    tv[1].x0 = mk(16'h4000, 16'h0100, 16'hFF00, 16'h0000);
    tv[1].c[0] = mk(16'h0000, 16'h0100, 16'h0000, 16'h0000);
    tv[1].k = mk(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    tv[1].y = 16'h0100;
    tv[1].xp = mk(16'h8000, 16'h0200, 16'hFE00, 16'h0000);
    tv[1].yh = 16'h0200;
    tv[1].xu = mk(16'h7F00, 16'h0100, 16'hFD00, 16'hFF00);

    tv[2].a = fill(16'h0080, 16'h0080);
    tv[2].x0 = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    tv[2].c[0] = mk(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    tv[2].k = mk(16'h0010, 16'h0000, 16'h0000, 16'h0020);
    tv[2].y = 16'h0000;
    tv[2].xp = mk(16'h0500, 16'h0500, 16'h0500, 16'h0500);
    tv[2].yh = 16'h0A00;
    tv[2].xu = mk(16'h0460, 16'h0500, 16'h0500, 16'h03C0);

    // Table vectors: reset state, predict, update.
    for (int t = 0; t < 3; t++) begin
      load(tv[t]);
      do_reset();
      chk($sformatf("tv%0d reset x_hat", t), x_hat, tv[t].x0);
      chk($sformatf("tv%0d reset flags", t), {end_Prediction, end_Update}, 2'b00);
      chk($sformatf("tv%0d reset y_hat", t), y_hat, 16'h0000);
      run_start(1'b1, 1'b0, 1'b0, n);
      chk($sformatf("tv%0d pred latency", t), n, 17);
      chk($sformatf("tv%0d x_pred", t), x_hat, tv[t].xp);
      run_start(1'b0, 1'b0, 1'b0, n);
      chk($sformatf("tv%0d upd latency", t), n, 18);
      chk($sformatf("tv%0d y_hat", t), y_hat, tv[t].yh);
      chk($sformatf("tv%0d x_upd", t), x_hat, tv[t].xu);
    end

    // Both starts in IDLE: prediction wins; starts in the done states are ignored.
    load(tv[2]);
    do_reset();
    run_start(1'b1, 1'b1, 1'b0, n);
    chk("both pred latency", n, 17);
    chk("both x_pred", x_hat, tv[2].xp);
    chk("both end_Update", end_Update, 1'b0);
    @(negedge clk) Start_Prediction = 1'b1;
    repeat (4) @(posedge clk);
    #1 Start_Prediction = 1'b0;
    chk("pred_done hold flag", end_Prediction, 1'b1);
    chk("pred_done hold x_hat", x_hat, tv[2].xp);
    run_start(1'b0, 1'b0, 1'b0, n);
    chk("after hold upd latency", n, 18);
    chk("after hold x_upd", x_hat, tv[2].xu);
    @(negedge clk) Start_Update = 1'b1;
    repeat (4) @(posedge clk);
    #1 Start_Update = 1'b0;
    chk("upd_done hold flag", end_Update, 1'b1);
    chk("upd_done hold x_hat", x_hat, tv[2].xu);

    // clk_en toggling every cycle: same results, twice the clock count.
    load(tv[2]);
    do_reset();
    run_start(1'b1, 1'b0, 1'b1, n);
    chk("gated pred latency", n, 34);
    chk("gated x_pred", x_hat, tv[2].xp);
    run_start(1'b0, 1'b0, 1'b1, n);
    chk("gated upd latency", n, 36);
    chk("gated y_hat", y_hat, tv[2].yh);
    chk("gated x_upd", x_hat, tv[2].xu);

    // Randomized runs: predict, update, predict again from UPD_DONE.
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NS; i++) begin
        for (int j = 0; j < NS; j++) r.a[i][j] = 16'($urandom);
        r.x0[i] = 16'($urandom);
        r.c[0][i] = 16'($urandom);
        r.k[i][0] = 16'($urandom);
      end
      r.y = 16'($urandom);
      load(r);
      do_reset();
      xp = m_pred(r.a, r.x0);
      yh = m_yh(r.c, xp);
      xu = m_upd(r.k, xp, r.y, yh);
      run_start(1'b1, 1'b0, it[0], n);
      chk($sformatf("rnd%0d pred latency", it), n, it[0] ? 34 : 17);
      chk($sformatf("rnd%0d x_pred", it), x_hat, xp);
      run_start(1'b0, 1'b0, 1'b0, n);
      chk($sformatf("rnd%0d upd latency", it), n, 18);
      chk($sformatf("rnd%0d y_hat", it), y_hat, yh);
      chk($sformatf("rnd%0d x_upd", it), x_hat, xu);
      run_start(1'b1, 1'b0, 1'b0, n);
      chk($sformatf("rnd%0d repred latency", it), n, 17);
      chk($sformatf("rnd%0d x_repred", it), x_hat, m_pred(r.a, xu));
    end

    // Reset at cycle 5 of PRED, entered from UPD_DONE with a nonzero y_hat.
    load(tv[2]);
    do_reset();
    run_start(1'b1, 1'b0, 1'b0, n);
    run_start(1'b0, 1'b0, 1'b0, n);
    @(negedge clk) Start_Prediction = 1'b1;
    @(posedge clk);
    #1 Start_Prediction = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midreset x_hat", x_hat, tv[2].x0);
    chk("midreset flags", {end_Prediction, end_Update}, 2'b00);
    chk("midreset y_hat", y_hat, 16'h0000);
    run_start(1'b1, 1'b0, 1'b0, n);
    chk("post reset pred latency", n, 17);
    chk("post reset x_pred", x_hat, tv[2].xp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
